// File: rtl/dma_tx_burst_cmd_mc.sv
// Multi-channel TX DMA burst command front end: assembles 3-word burst posts per channel,
// queues descriptors per channel, drops late bursts and round-robins them onto one bufcmd stream.
module dma_tx_burst_cmd_mc #(
  parameter int NUM_CH         = 2,
  parameter int CH_BITS        = 1,
  parameter int TIMESTAMP_BITS = 49,
  parameter int BURSTS_BITS    = 5,
  parameter int SAMPLES_WIDTH  = 13,
  parameter int BYTES_WIDTH    = 15,
  parameter int FIFO_AW        = 4,
  localparam int DESCR_W       = 1 + TIMESTAMP_BITS + BURSTS_BITS + SAMPLES_WIDTH + BYTES_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CH_BITS-1:0]         s_cmd_ch,
  input  logic [31:0]                s_cmd_data,
  input  logic                       s_cmd_valid,
  output logic                       s_cmd_ready,
  input  logic [CH_BITS-1:0]         s_ctrl_ch,
  input  logic [1:0]                 s_ctrl_data,
  input  logic                       s_ctrl_valid,
  input  logic [TIMESTAMP_BITS-1:0]  s_cur_ts,
  output logic                       m_bufcmd_valid,
  input  logic                       m_bufcmd_ready,
  output logic [CH_BITS-1:0]         m_bufcmd_ch,
  output logic [DESCR_W-1:0]         m_bufcmd_data,
  output logic [NUM_CH-1:0]          ch_active,
  output logic [NUM_CH*16-1:0]       stat_posted,
  output logic [NUM_CH*16-1:0]       stat_late,
  output logic [NUM_CH*16-1:0]       stat_badcmd
);

  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int TS_LSB = BYTES_WIDTH + SAMPLES_WIDTH + BURSTS_BITS;
  localparam int W1_W   = TIMESTAMP_BITS - 31;

  typedef enum logic [1:0] {ST_W0 = 2'd0, ST_W1 = 2'd1, ST_W2 = 2'd2} asm_state_t;

  asm_state_t                 asm_state_r   [NUM_CH];
  asm_state_t                 asm_state_nxt_s [NUM_CH];
  logic [31:0]                w0_r          [NUM_CH];
  logic [W1_W-1:0]            w1_r          [NUM_CH];
  logic [DESCR_W-1:0]         fifo_mem_r    [NUM_CH][DEPTH];
  logic [FIFO_AW:0]           wr_ptr_r      [NUM_CH];
  logic [FIFO_AW:0]           rd_ptr_r      [NUM_CH];
  logic [15:0]                posted_r      [NUM_CH];
  logic [15:0]                late_r        [NUM_CH];
  logic [15:0]                bad_r         [NUM_CH];
  logic [DESCR_W-1:0]         new_descr_s   [NUM_CH];
  logic [NUM_CH-1:0]          ch_active_r;
  logic [NUM_CH-1:0]          full_s, empty_s, ctrl_hit_s, stop_s, start_s;
  logic [NUM_CH-1:0]          cmd_hit_s, word_s, bad_s, push_s, pop_s;
  logic                       cmd_ready_s;
  logic [CH_BITS-1:0]         rr_r;
  logic                       out_valid_r;
  logic [CH_BITS-1:0]         out_ch_r;
  logic [DESCR_W-1:0]         out_data_r;
  logic                       fire_s, out_stop_s, grant_s, grant_late_s;
  logic [CH_BITS-1:0]         grant_ch_s;
  logic [DESCR_W-1:0]         grant_data_s;
  int                         arb_idx_s;

  // Per-channel decode of control strobes, FIFO levels and command acceptance.
  always_comb begin
    cmd_ready_s = 1'b1;
    full_s      = '0;
    empty_s     = '0;
    ctrl_hit_s  = '0;
    stop_s      = '0;
    start_s     = '0;
    cmd_hit_s   = '0;
    word_s      = '0;
    bad_s       = '0;
    push_s      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      full_s[c]     = (wr_ptr_r[c][FIFO_AW] != rd_ptr_r[c][FIFO_AW]) &&
                      (wr_ptr_r[c][FIFO_AW-1:0] == rd_ptr_r[c][FIFO_AW-1:0]);
      empty_s[c]    = (wr_ptr_r[c] == rd_ptr_r[c]);
      ctrl_hit_s[c] = s_ctrl_valid && (s_ctrl_ch == CH_BITS'(c));
      stop_s[c]     = ctrl_hit_s[c] && (s_ctrl_data == 2'b00) && ch_active_r[c];
      start_s[c]    = ctrl_hit_s[c] && (s_ctrl_data == 2'b11) && !ch_active_r[c];
      if ((s_cmd_ch == CH_BITS'(c)) && ch_active_r[c] && (asm_state_r[c] == ST_W2) && full_s[c]) begin
        cmd_ready_s = 1'b0;
      end else begin
        cmd_ready_s = cmd_ready_s;
      end
    end
    // Channel indices beyond NUM_CH match no channel, so such words are swallowed silently.
    for (int c = 0; c < NUM_CH; c++) begin
      cmd_hit_s[c] = s_cmd_valid && cmd_ready_s && (s_cmd_ch == CH_BITS'(c));
      word_s[c]    = cmd_hit_s[c] && ch_active_r[c];
      bad_s[c]     = cmd_hit_s[c] && !ch_active_r[c];
      push_s[c]    = word_s[c] && (asm_state_r[c] == ST_W2) && !stop_s[c];
    end
  end

  // Assembly FSM next state and the descriptor formed by the final word.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      asm_state_nxt_s[c] = asm_state_r[c];
      new_descr_s[c] = {w1_r[c], s_cmd_data, w0_r[c][31 -: BURSTS_BITS], w0_r[c][14 +: SAMPLES_WIDTH],
                        {(BYTES_WIDTH-14){1'b0}}, w0_r[c][13:0]};
      if (stop_s[c]) begin
        asm_state_nxt_s[c] = ST_W0;
      end else if (word_s[c]) begin
        case (asm_state_r[c])
          ST_W0:   asm_state_nxt_s[c] = ST_W1;
          ST_W1:   asm_state_nxt_s[c] = ST_W2;
          ST_W2:   asm_state_nxt_s[c] = ST_W0;
          default: asm_state_nxt_s[c] = ST_W0;
        endcase
      end else begin
        asm_state_nxt_s[c] = asm_state_r[c];
      end
    end
  end

  // Round-robin arbiter; a channel being stopped this cycle is treated as empty.
  always_comb begin
    fire_s       = out_valid_r && m_bufcmd_ready;
    out_stop_s   = out_valid_r && stop_s[out_ch_r];
    grant_s      = 1'b0;
    grant_ch_s   = '0;
    grant_data_s = '0;
    pop_s        = '0;
    arb_idx_s    = 0;
    if (!out_valid_r || fire_s) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        arb_idx_s = (int'(rr_r) + k) % NUM_CH;
        if (!grant_s && !empty_s[arb_idx_s] && !stop_s[arb_idx_s]) begin
          grant_s           = 1'b1;
          grant_ch_s        = CH_BITS'(arb_idx_s);
          grant_data_s      = fifo_mem_r[arb_idx_s][rd_ptr_r[arb_idx_s][FIFO_AW-1:0]];
          pop_s[arb_idx_s]  = 1'b1;
        end else begin
          grant_s = grant_s;
        end
      end
    end else begin
      grant_s = 1'b0;
    end
    grant_late_s = grant_s && !grant_data_s[DESCR_W-1] &&
                   (grant_data_s[TS_LSB +: TIMESTAMP_BITS] < s_cur_ts);
  end

  // Assembly state register.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) asm_state_r[c] <= ST_W0;
      else     asm_state_r[c] <= asm_state_nxt_s[c];
    end
  end

  // Datapath storage (partial words and FIFO contents) needs no reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (word_s[c] && (asm_state_r[c] == ST_W0)) w0_r[c] <= s_cmd_data;
      if (word_s[c] && (asm_state_r[c] == ST_W1)) w1_r[c] <= {s_cmd_data[31], s_cmd_data[TIMESTAMP_BITS-33:0]};
      if (push_s[c]) fifo_mem_r[c][wr_ptr_r[c][FIFO_AW-1:0]] <= new_descr_s[c];
    end
  end

  // Channel activity, FIFO pointers and statistics; start clears stats, stop flushes the FIFO.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        ch_active_r[c] <= 1'b0;
        wr_ptr_r[c]    <= '0;
        rd_ptr_r[c]    <= '0;
        posted_r[c]    <= 16'd0;
        late_r[c]      <= 16'd0;
        bad_r[c]       <= 16'd0;
      end else if (start_s[c]) begin
        ch_active_r[c] <= 1'b1;
        posted_r[c]    <= 16'd0;
        late_r[c]      <= 16'd0;
        bad_r[c]       <= 16'd0;
      end else if (stop_s[c]) begin
        ch_active_r[c] <= 1'b0;
        wr_ptr_r[c]    <= '0;
        rd_ptr_r[c]    <= '0;
      end else begin
        if (push_s[c]) wr_ptr_r[c] <= wr_ptr_r[c] + 1'b1;
        if (pop_s[c])  rd_ptr_r[c] <= rd_ptr_r[c] + 1'b1;
        if (push_s[c]) posted_r[c] <= posted_r[c] + 16'd1;
        if (pop_s[c] && grant_late_s) late_r[c] <= late_r[c] + 16'd1;
        if (bad_s[c])  bad_r[c] <= bad_r[c] + 16'd1;
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_ch_r    <= '0;
      out_data_r  <= '0;
      rr_r        <= '0;
    end else if (grant_s) begin
      out_valid_r <= !grant_late_s;
      out_ch_r    <= grant_ch_s;
      out_data_r  <= grant_data_s;
      rr_r        <= grant_ch_s;
    end else if (fire_s || out_stop_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign s_cmd_ready    = cmd_ready_s;
  assign m_bufcmd_valid = out_valid_r;
  assign m_bufcmd_ch    = out_ch_r;
  assign m_bufcmd_data  = out_data_r;
  assign ch_active      = ch_active_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
    assign stat_posted[g*16 +: 16] = posted_r[g];
    assign stat_late[g*16 +: 16]   = late_r[g];
    assign stat_badcmd[g*16 +: 16] = bad_r[g];
  end

endmodule

// File: tb/tb_dma_tx_burst_cmd_mc.sv
// Directed bench for dma_tx_burst_cmd_mc: a vector table for the basic post, then
// hand-written sequences for arbitration, late drop, FIFO full, stop/restart and hold.
module tb_dma_tx_burst_cmd_mc;
  localparam int DW = 83;

  logic          clk = 1'b0;
  logic          rst;
  logic [0:0]    s_cmd_ch;
  logic [31:0]   s_cmd_data;
  logic          s_cmd_valid;
  logic          s_cmd_ready;
  logic [0:0]    s_ctrl_ch;
  logic [1:0]    s_ctrl_data;
  logic          s_ctrl_valid;
  logic [48:0]   s_cur_ts;
  logic          m_bufcmd_valid;
  logic          m_bufcmd_ready;
  logic [0:0]    m_bufcmd_ch;
  logic [DW-1:0] m_bufcmd_data;
  logic [1:0]    ch_active;
  logic [31:0]   stat_posted, stat_late, stat_badcmd;

  int checks = 0;
  int errors = 0;
  int fire_total = 0;
  int fire_base;

  typedef struct {
    logic          cv;
    logic          cch;
    logic [31:0]   cd;
    logic          tv;
    logic          tch;
    logic [1:0]    td;
    logic          rdy_in;
    logic          e_rdy;
    logic          e_vld;
    logic [1:0]    e_act;
    logic [DW-1:0] e_data;
  } vec_t;
  vec_t vt[7];

  dma_tx_burst_cmd_mc #(.FIFO_AW(2)) dut (
    .clk(clk), .rst(rst),
    .s_cmd_ch(s_cmd_ch), .s_cmd_data(s_cmd_data), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_ctrl_ch(s_ctrl_ch), .s_ctrl_data(s_ctrl_data), .s_ctrl_valid(s_ctrl_valid),
    .s_cur_ts(s_cur_ts),
    .m_bufcmd_valid(m_bufcmd_valid), .m_bufcmd_ready(m_bufcmd_ready),
    .m_bufcmd_ch(m_bufcmd_ch), .m_bufcmd_data(m_bufcmd_data),
    .ch_active(ch_active), .stat_posted(stat_posted), .stat_late(stat_late), .stat_badcmd(stat_badcmd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (m_bufcmd_valid && m_bufcmd_ready) fire_total++;

  function automatic logic [DW-1:0] descr(input logic nots, input logic [48:0] ts);
    return {nots, ts, 5'd1, 13'd1, 15'd4};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic ch, input logic [31:0] d);
    int n;
    n = 0;
    s_cmd_ch = ch; s_cmd_data = d; s_cmd_valid = 1'b1;
    @(negedge clk);
    while (!s_cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept_timeout", {95'd0, s_cmd_ready}, 96'd1);
    nxt();
    s_cmd_valid = 1'b0;
  endtask

  task automatic post(input logic ch, input logic nots, input logic [48:0] ts);
    send_word(ch, 32'h0800_4004);
    send_word(ch, {nots, 14'd0, ts[48:32]});
    send_word(ch, ts[31:0]);
  endtask

  task automatic ctrl(input logic ch, input logic [1:0] d);
    s_ctrl_ch = ch; s_ctrl_data = d; s_ctrl_valid = 1'b1;
    nxt();
    s_ctrl_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!m_bufcmd_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk(name, {95'd0, m_bufcmd_valid}, 96'd1);
  endtask

  initial begin
    rst = 1'b1; s_cmd_ch = '0; s_cmd_data = 32'd0; s_cmd_valid = 1'b0;
    s_ctrl_ch = '0; s_ctrl_data = 2'b01; s_ctrl_valid = 1'b0;
    s_cur_ts = 49'd0; m_bufcmd_ready = 1'b1;

    //      cv    cch   cd             tv    tch   td     rdy   e_rdy e_vld e_act  e_data
    vt[0] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 2'b00, {DW{1'b0}}};
    vt[1] = '{1'b1, 1'b0, 32'h0800_4004, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, {DW{1'b0}}};
    vt[2] = '{1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, {DW{1'b0}}};
    vt[3] = '{1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, {DW{1'b0}}};
    vt[4] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, {DW{1'b0}}};
    vt[5] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 2'b01,
              {1'b0, 49'h1_0000_0100, 5'd1, 13'd1, 15'd4}};
    vt[6] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, {DW{1'b0}}};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", {95'd0, m_bufcmd_valid}, 96'd0);
    chk("rst_active", {94'd0, ch_active}, 96'd0);
    chk("rst_posted", {64'd0, stat_posted}, 96'd0);
    chk("rst_late", {64'd0, stat_late}, 96'd0);
    chk("rst_badcmd", {64'd0, stat_badcmd}, 96'd0);
    nxt();
    rst = 1'b0;

    // basic post through the vector table
    for (int i = 0; i < 7; i++) begin
      s_cmd_valid = vt[i].cv; s_cmd_ch = vt[i].cch; s_cmd_data = vt[i].cd;
      s_ctrl_valid = vt[i].tv; s_ctrl_ch = vt[i].tch; s_ctrl_data = vt[i].td;
      m_bufcmd_ready = vt[i].rdy_in;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), {95'd0, s_cmd_ready}, {95'd0, vt[i].e_rdy});
      chk($sformatf("vec%0d_valid", i), {95'd0, m_bufcmd_valid}, {95'd0, vt[i].e_vld});
      chk($sformatf("vec%0d_active", i), {94'd0, ch_active}, {94'd0, vt[i].e_act});
      if (vt[i].e_vld) begin
        chk($sformatf("vec%0d_data", i), {13'd0, m_bufcmd_data}, {13'd0, vt[i].e_data});
        chk($sformatf("vec%0d_ch", i), {95'd0, m_bufcmd_ch}, 96'd0);
      end
      nxt();
    end
    s_cmd_valid = 1'b0; s_ctrl_valid = 1'b0;
    chk("t1_posted0", {80'd0, stat_posted[15:0]}, 96'd1);

    // round-robin: queue 3 posts per channel behind a stalled output, then drain
    ctrl(1'b1, 2'b11);
    m_bufcmd_ready = 1'b0;
    for (int k = 0; k < 3; k++) post(1'b0, 1'b1, 49'(k));
    for (int k = 0; k < 3; k++) post(1'b1, 1'b1, 49'(10 + k));
    m_bufcmd_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_valid", k), {95'd0, m_bufcmd_valid}, 96'd1);
      chk($sformatf("rr%0d_ch", k), {95'd0, m_bufcmd_ch}, 96'(k % 2));
      chk($sformatf("rr%0d_ts", k), {64'd0, m_bufcmd_data[33 +: 32]}, 96'((k % 2) * 10 + k / 2));
    end
    @(negedge clk);
    chk("rr_idle", {95'd0, m_bufcmd_valid}, 96'd0);
    chk("t2_posted", {64'd0, stat_posted}, {64'd0, 16'd3, 16'd4});
    nxt();

    // late drop, nots bypass and ts == cur_ts boundary
    s_cur_ts = 49'd200;
    post(1'b0, 1'b0, 49'd100);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("late%0d_novalid", k), {95'd0, m_bufcmd_valid}, 96'd0);
    end
    chk("late_count", {80'd0, stat_late[15:0]}, 96'd1);
    nxt();
    post(1'b0, 1'b1, 49'd100);
    wait_valid("nots_wait");
    chk("nots_data", {13'd0, m_bufcmd_data}, {13'd0, descr(1'b1, 49'd100)});
    nxt();
    post(1'b0, 1'b0, 49'd200);
    wait_valid("eq_ts_wait");
    chk("eq_ts_data", {13'd0, m_bufcmd_data}, {13'd0, descr(1'b0, 49'd200)});
    chk("eq_ts_late", {80'd0, stat_late[15:0]}, 96'd1);
    nxt();
    s_cur_ts = 49'd0;

    // FIFO full: output register plus 4 FIFO entries, 6th W2 must stall
    m_bufcmd_ready = 1'b0;
    fire_base = fire_total;
    for (int k = 0; k < 5; k++) post(1'b0, 1'b1, 49'(16'h1000 + k));
    send_word(1'b0, 32'h0800_4004);
    send_word(1'b0, 32'h8000_0000);
    s_cmd_ch = 1'b0; s_cmd_data = 32'h0000_1005; s_cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("full%0d_ready", k), {95'd0, s_cmd_ready}, 96'd0);
      nxt();
    end
    m_bufcmd_ready = 1'b1;
    send_word(1'b0, 32'h0000_1005);
    repeat (15) @(negedge clk);
    chk("full_drain_count", 96'(fire_total - fire_base), 96'd6);
    chk("full_posted0", {80'd0, stat_posted[15:0]}, 96'd13);
    nxt();

    // stop ch1 mid-post, stray W2 counted as bad, restart clears stats
    fire_base = fire_total;
    send_word(1'b1, 32'h0800_4004);
    send_word(1'b1, 32'h8000_0000);
    ctrl(1'b1, 2'b00);
    @(negedge clk);
    chk("stop_active", {94'd0, ch_active}, 96'd1);
    nxt();
    send_word(1'b1, 32'h0000_0066);
    repeat (4) @(negedge clk);
    chk("stop_no_output", 96'(fire_total - fire_base), 96'd0);
    chk("stop_badcmd1", {80'd0, stat_badcmd[31:16]}, 96'd1);
    chk("stop_posted1", {80'd0, stat_posted[31:16]}, 96'd3);
    nxt();
    ctrl(1'b1, 2'b11);
    @(negedge clk);
    chk("restart_badcmd1", {80'd0, stat_badcmd[31:16]}, 96'd0);
    chk("restart_active", {94'd0, ch_active}, 96'd3);
    nxt();
    post(1'b1, 1'b1, 49'h77);
    wait_valid("restart_wait");
    chk("restart_ch", {95'd0, m_bufcmd_ch}, 96'd1);
    chk("restart_ts", {64'd0, m_bufcmd_data[33 +: 32]}, 96'h77);
    chk("restart_posted1", {80'd0, stat_posted[31:16]}, 96'd1);
    nxt();

    // hold under back-pressure, then stop the held channel
    m_bufcmd_ready = 1'b0;
    post(1'b1, 1'b1, 49'h55);
    wait_valid("hold_wait");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d_valid", k), {95'd0, m_bufcmd_valid}, 96'd1);
      chk($sformatf("hold%0d_ch", k), {95'd0, m_bufcmd_ch}, 96'd1);
      chk($sformatf("hold%0d_data", k), {13'd0, m_bufcmd_data}, {13'd0, descr(1'b1, 49'h55)});
      @(negedge clk);
    end
    nxt();
    s_ctrl_ch = 1'b1; s_ctrl_data = 2'b00; s_ctrl_valid = 1'b1;
    @(negedge clk);
    chk("hold_stop_pre", {95'd0, m_bufcmd_valid}, 96'd1);
    nxt();
    s_ctrl_valid = 1'b0;
    @(negedge clk);
    chk("hold_stop_drop", {95'd0, m_bufcmd_valid}, 96'd0);
    chk("hold_stop_active", {94'd0, ch_active}, 96'd1);
    chk("final_late0", {80'd0, stat_late[15:0]}, 96'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
